vga_scan_ctrl: RTL and testbench

Display-side counterpart of the sprite/pixel generators. Generates 640x480@60 Hz VGA timing from the system clock, publishes the current pixel coordinate (`pixel_X`, `pixel_Y`) and active-low read strobe `rdn` to the pixel sources, then samples their 12-bit colour and drives `r`/`g`/`b`/`hs`/`vs` with matched alignment. Sits between the player/background renderers and the board VGA connector.

---
 rtl/vga_scan_ctrl_if.sv | 35 +++
 rtl/vga_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl_if
// Bundles the scan controller's pixel-source request/response bus and the
// VGA pin outputs into one connection.
//   data_in      12  colour {R,G,B} returned by the pixel sources
//   pixel_X      10  column of the requested pixel
//   pixel_Y       9  row of the requested pixel
//   rdn           1  active-low "visible pixel, data wanted" strobe
//   r/g/b       4 ea VGA colour
//   hs/vs         1  active-low sync
//   frame_start   1  one-clk pulse when (0,0) is requested
// master = the scan controller, slave = the pixel sources / board pins side.
// -----------------------------------------------------------------------------
interface vga_scan_ctrl_if;
  logic [11:0] data_in;
  logic [9:0]  pixel_X;
  logic [8:0]  pixel_Y;
  logic        rdn;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hs;
  logic        vs;
  logic        frame_start;

  modport master (
    input  data_in,
    output pixel_X, pixel_Y, rdn, r, g, b, hs, vs, frame_start
  );

  modport slave (
    output data_in,
    input  pixel_X, pixel_Y, rdn, r, g, b, hs, vs, frame_start
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl
// Generates VGA raster timing (640x480@60 Hz by default) from the system clock.
// Stage 0 publishes the pixel coordinate and read strobe to the pixel sources;
// stage 1, one pixel tick later, samples their colour and drives the pins with
// the sync signals delayed by the same tick so colour and sync stay aligned.
// Ports:
//   clk   system clock (only clock)
//   clrn  synchronous active-low reset
//   vga   vga_scan_ctrl_if.master (coordinate request, colour in, VGA pins)
// -----------------------------------------------------------------------------
module vga_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic            clk,
  input  logic            clrn,
  vga_scan_ctrl_if.master vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [9:0]       pixel_x_q, pixel_x_d;
  logic [8:0]       pixel_y_q, pixel_y_d;
  logic             rdn_q, rdn_d;
  logic             hs_req_q, hs_req_d;
  logic             vs_req_q, vs_req_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             frame_start_q, frame_start_d;

  logic tick;
  logic visible;
  logic hs_raw;
  logic vs_raw;

  // h_cnt/v_cnt name the position that the next tick will publish, so the
  // very first tick after reset requests (0,0) and the counters step past it.
  // Stage-0 registers load from the counters as they stand before the step.
  always_comb begin
    tick    = (div_q == DIV_LAST);
    visible = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    hs_raw  = !((h_q >= HS_START) && (h_q < HS_END));
    vs_raw  = !((v_q >= VS_START) && (v_q < VS_END));

    div_d         = tick ? '0 : div_q + DIV_W'(1);
    h_d           = h_q;
    v_d           = v_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    rdn_d         = rdn_q;
    hs_req_d      = hs_req_q;
    vs_req_d      = vs_req_q;
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    frame_start_d = tick && (h_q == 10'd0) && (v_q == 10'd0);

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end

      // Coordinates freeze at the last visible pixel during blanking so the
      // sources never see an out-of-range address.
      rdn_d    = !visible;
      hs_req_d = hs_raw;
      vs_req_d = vs_raw;
      if (visible) begin
        pixel_x_d = h_q;
        pixel_y_d = v_q[8:0];
      end

      // Stage 1 uses the previous request's strobe, which is exactly the
      // request the sampled data_in answers.
      rgb_d = rdn_q ? 12'h000 : vga.data_in;
      hs_d  = hs_req_q;
      vs_d  = vs_req_q;
    end
  end

  // All state, including the prescaler, returns to its idle values on any
  // clock edge with clrn low, so a reset mid-line cuts sync pulses cleanly.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      div_q         <= '0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 9'd0;
      rdn_q         <= 1'b1;
      hs_req_q      <= 1'b1;
      vs_req_q      <= 1'b1;
      rgb_q         <= 12'h000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      rdn_q         <= rdn_d;
      hs_req_q      <= hs_req_d;
      vs_req_q      <= vs_req_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_X     = pixel_x_q;
  assign vga.pixel_Y     = pixel_y_q;
  assign vga.rdn         = rdn_q;
  assign vga.r           = rgb_q[11:8];
  assign vga.g           = rgb_q[7:4];
  assign vga.b           = rgb_q[3:0];
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_ctrl
// Drives vga_scan_ctrl with a reduced raster geometry so whole frames fit in a
// short run. A pixel-source model answers each visible request with a salted
// colour and feeds random junk (often 12'hFFF) while blanked. Expected outputs
// are derived from the number of clock edges since reset: edge count -> tick
// count -> raster position -> visibility, sync and colour by plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int HV = 20, HFP = 3, HSY = 5, HBP = 4;
  localparam int VV = 12, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic clrn;

  int          edgeCount;
  int          checkCount;
  int          errorCount;
  logic [11:0] salt;

  vga_scan_ctrl_if bus();

  vga_scan_ctrl #(
    .CLK_DIV(CLK_DIV),
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .vga (bus)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Colour the pixel sources return for a coordinate.
  function automatic logic [11:0] colourAt(input logic [9:0] x, input logic [8:0] y);
    return {x[3:0], y[3:0], 4'hA} ^ salt;
  endfunction

  function automatic logic posVisible(input int p);
    return ((p % HT) < HV) && ((p / HT) < VV);
  endfunction

  // Compares one observed value with its expected value and records it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h edge=%0d t=%0t", tag, obs, exp, edgeCount, $time);
    end
  endtask

  // Works out what every output should be after edgeCount edges since reset.
  task automatic checkAll();
    int k, p, q, h, v, ex, ey, hq, vq;
    logic eRdn, eHs, eVs, eFs;
    logic [11:0] eRgb;
    k = edgeCount / CLK_DIV;
    if (k == 0) begin
      eRdn = 1'b1; ex = 0; ey = 0; eHs = 1'b1; eVs = 1'b1; eRgb = 12'h000; eFs = 1'b0;
    end else begin
      p = (k - 1) % FRAME;
      h = p % HT;
      v = p / HT;
      eRdn = !posVisible(p);
      if (v < VV) begin
        ey = v;
        ex = (h < HV) ? h : HV - 1;
      end else begin
        ex = HV - 1;
        ey = VV - 1;
      end
      eFs = ((edgeCount % CLK_DIV) == 0) && (p == 0);
      if (k == 1) begin
        eHs = 1'b1; eVs = 1'b1; eRgb = 12'h000;
      end else begin
        q  = (k - 2) % FRAME;
        hq = q % HT;
        vq = q / HT;
        eHs  = !((hq >= HV + HFP) && (hq < HV + HFP + HSY));
        eVs  = !((vq >= VV + VFP) && (vq < VV + VFP + VSY));
        eRgb = posVisible(q) ? colourAt(10'(hq), 9'(vq)) : 12'h000;
      end
    end
    checkOutput("rdn",         32'(bus.rdn),                  32'(eRdn));
    checkOutput("pixel_X",     32'(bus.pixel_X),              32'(ex));
    checkOutput("pixel_Y",     32'(bus.pixel_Y),              32'(ey));
    checkOutput("hs",          32'(bus.hs),                   32'(eHs));
    checkOutput("vs",          32'(bus.vs),                   32'(eVs));
    checkOutput("rgb",         32'({bus.r, bus.g, bus.b}),    32'(eRgb));
    checkOutput("frame_start", 32'(bus.frame_start),          32'(eFs));
  endtask

  // One system clock: set clrn, take the edge, check on the falling edge, then
  // let the pixel-source model answer the current request.
  task automatic applyStimulus(input logic rstVal);
    clrn = rstVal;
    @(posedge clk);
    if (!rstVal) edgeCount = 0;
    else edgeCount++;
    @(negedge clk);
    checkAll();
    if (bus.rdn == 1'b0)
      bus.data_in = colourAt(bus.pixel_X, bus.pixel_Y);
    else
      bus.data_in = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom);
  endtask

  task automatic holdReset(input int cycles);
    salt = 12'($urandom);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0);
  endtask

  task automatic runCycles(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1);
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    edgeCount   = 0;
    salt        = 12'h000;
    bus.data_in = 12'h000;
    clrn        = 1'b0;

    $display("[TB] reset and two full frames");
    holdReset(10);
    runCycles(2 * FRAME * CLK_DIV + 700);

    $display("[TB] random mid-frame resets");
    for (int r = 0; r < 8; r++) begin
      holdReset($urandom_range(1, 5));
      runCycles($urandom_range(50, 3000));
    end

    $display("[TB] reset mid-line in the middle of the frame");
    holdReset(2);
    runCycles(CLK_DIV * (6 * HT + 10) + 2);
    holdReset(1);
    runCycles(FRAME * CLK_DIV + 50);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
